// File: rtl/pattern_board_gen.sv
// Random board generator: draws LFSR candidates until one has an acceptable lit-cell count,
// else falls back to a fixed pattern. Optional seed loading via PATTERN_BOARD_GEN_SEED_LOAD_EN.
module pattern_board_gen #(
  parameter int          CELLS     = 16,
  parameter int          MIN_LIT   = 3,
  parameter int          MAX_LIT   = 8,
  parameter int          MAX_TRIES = 15,
  parameter logic [31:0] SEED      = 32'hACE10001
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       board_ack,
  output logic [CELLS-1:0]           board,
  output logic [$clog2(CELLS+1)-1:0] lit_count,
  output logic                       board_valid,
  output logic                       busy,
  output logic                       fallback
`ifdef PATTERN_BOARD_GEN_SEED_LOAD_EN
  ,
  input  logic                       seed_load,
  input  logic [31:0]                seed_in
`endif
);

  localparam int LW = $clog2(CELLS + 1);
  localparam logic [LW-1:0]    MIN_C    = LW'(MIN_LIT);
  localparam logic [LW-1:0]    MAX_C    = LW'(MAX_LIT);
  localparam logic [7:0]       TRY_LAST = 8'(MAX_TRIES - 1);
  localparam logic [CELLS-1:0] FALLBACK = CELLS'((64'd1 << MIN_LIT) - 64'd1);
  // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0]      TAPS     = 32'h8020_0003;

  if (CELLS < 4 || CELLS > 32) begin : g_bad_cells
    $error("pattern_board_gen: CELLS=%0d outside 4..32", CELLS);
  end
  if (!(MIN_LIT >= 1 && MIN_LIT <= MAX_LIT && MAX_LIT <= CELLS)) begin : g_bad_lit
    $error("pattern_board_gen: need 1<=MIN_LIT<=MAX_LIT<=CELLS");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_tries
    $error("pattern_board_gen: MAX_TRIES=%0d outside 1..255", MAX_TRIES);
  end

  typedef enum logic [1:0] {IDLE, ARM, DRAW, SHOW} state_t;

  state_t            state, state_next;
  logic [31:0]       lfsr, lfsr_next;
  logic [7:0]        tries, tries_next;
  logic [CELLS-1:0]  candidate;
  logic [LW-1:0]     cand_count;
  logic              in_range, accept, give_up;

  function automatic logic [LW-1:0] popcount(input logic [CELLS-1:0] v);
    logic [LW-1:0] n;
    n = '0;
    for (int i = 0; i < CELLS; i++) n = n + LW'(v[i]);
    return n;
  endfunction

  assign lfsr_next  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
  assign candidate  = lfsr[CELLS-1:0];
  assign cand_count = popcount(candidate);
  assign in_range   = (cand_count >= MIN_C) && (cand_count <= MAX_C);

  assign busy        = (state == ARM) || (state == DRAW);
  assign board_valid = (state == SHOW);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    tries_next = tries;
    accept     = 1'b0;
    give_up    = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = ARM;
      ARM: begin
        if (!start) begin
          state_next = DRAW;
          tries_next = '0;
        end
      end
      DRAW: begin
        if (in_range) begin
          accept     = 1'b1;
          state_next = SHOW;
        end else if (tries == TRY_LAST) begin
          give_up    = 1'b1;
          state_next = SHOW;
        end else begin
          tries_next = tries + 8'd1;
        end
      end
      SHOW: if (board_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lfsr      <= SEED;
      tries     <= '0;
      board     <= '0;
      lit_count <= '0;
      fallback  <= 1'b0;
    end else begin
      state <= state_next;
      tries <= tries_next;
`ifdef PATTERN_BOARD_GEN_SEED_LOAD_EN
      if (seed_load) lfsr <= (seed_in == 32'h0) ? SEED : seed_in;
      else           lfsr <= lfsr_next;
`else
      lfsr <= lfsr_next;
`endif
      if (accept) begin
        board     <= candidate;
        lit_count <= cand_count;
        fallback  <= 1'b0;
      end else if (give_up) begin
        board     <= FALLBACK;
        lit_count <= MIN_C;
        fallback  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_board_gen.sv
// Self-checking bench for pattern_board_gen: a default instance and a forced-fallback
// instance, predicted from a free-running reference LFSR and the acceptance rules.
module tb_pattern_board_gen;

  localparam int C0 = 16, MIN0 = 3, MAX0 = 8, T0 = 15;
  localparam int C1 = 8,  MIN1 = 8, MAX1 = 8, T1 = 4;
  localparam logic [31:0] SEED = 32'hACE10001;
  localparam int MAXW = 40;

  logic clk = 1'b0;
  logic reset;
  logic start0, ack0, start1, ack1;
  logic [15:0] board0;
  logic [4:0]  lit0;
  logic        valid0, busy0, fb0;
  logic [7:0]  board1;
  logic [3:0]  lit1;
  logic        valid1, busy1, fb1;

  always #5 clk = ~clk;

  pattern_board_gen dut (
    .clk(clk), .reset(reset), .start(start0), .board_ack(ack0),
    .board(board0), .lit_count(lit0), .board_valid(valid0), .busy(busy0), .fallback(fb0)
`ifdef PATTERN_BOARD_GEN_SEED_LOAD_EN
    , .seed_load(1'b0), .seed_in(32'h0)
`endif
  );

  pattern_board_gen #(.CELLS(C1), .MIN_LIT(MIN1), .MAX_LIT(MAX1), .MAX_TRIES(T1)) dut8 (
    .clk(clk), .reset(reset), .start(start1), .board_ack(ack1),
    .board(board1), .lit_count(lit1), .board_valid(valid1), .busy(busy1), .fallback(fb1)
`ifdef PATTERN_BOARD_GEN_SEED_LOAD_EN
    , .seed_load(1'b0), .seed_in(32'h0)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_lfsr;
  logic [31:0] prev_board [2];
  logic [31:0] prev_lit   [2];
  logic        prev_fb    [2];

  // Multiplication by x modulo the feedback polynomial, right-shift Galois form.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
    return t;
  endfunction

  function automatic int popc(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  always @(posedge clk) if (!reset) m_lfsr = lfsr_step(m_lfsr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_board(input int w);
    return (w == 0) ? 32'(board0) : 32'(board1);
  endfunction
  function automatic logic [31:0] get_lit(input int w);
    return (w == 0) ? 32'(lit0) : 32'(lit1);
  endfunction
  function automatic logic get_valid(input int w);
    return (w == 0) ? valid0 : valid1;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 0) ? busy0 : busy1;
  endfunction
  function automatic logic get_fb(input int w);
    return (w == 0) ? fb0 : fb1;
  endfunction

  task automatic drive_start(input int w, input logic v);
    if (w == 0) start0 = v; else start1 = v;
  endtask
  task automatic drive_ack(input int w, input logic v);
    if (w == 0) ack0 = v; else ack1 = v;
  endtask

  task automatic check_all_zero(input string tag);
    for (int w = 0; w < 2; w++) begin
      check({tag, "_board"}, get_board(w), 32'h0);
      check({tag, "_lit"},   get_lit(w),   32'h0);
      check({tag, "_valid"}, 32'(get_valid(w)), 32'h0);
      check({tag, "_busy"},  32'(get_busy(w)),  32'h0);
      check({tag, "_fb"},    32'(get_fb(w)),    32'h0);
    end
  endtask

  task automatic clear_prev();
    for (int w = 0; w < 2; w++) begin
      prev_board[w] = '0;
      prev_lit[w]   = '0;
      prev_fb[w]    = 1'b0;
    end
  endtask

  // Hold start for `hold` cycles (ARM), then release it; the next edge is the one ARM sees low.
  task automatic press(input int w, input int hold, input logic with_ack);
    @(negedge clk);
    drive_start(w, 1'b1);
    drive_ack(w, with_ack);
    repeat (hold) @(negedge clk);
    check("arm_busy",  32'(get_busy(w)),  32'h1);
    check("arm_valid", 32'(get_valid(w)), 32'h0);
    drive_ack(w, 1'b0);
    drive_start(w, 1'b0);
  endtask

  task automatic draw_and_check(input int w);
    int mn, mx, tr, cells, lat, exp_lat;
    logic [31:0] s, cand, exp_board;
    logic exp_fb, found;
    mn    = (w == 0) ? MIN0 : MIN1;
    mx    = (w == 0) ? MAX0 : MAX1;
    tr    = (w == 0) ? T0   : T1;
    cells = (w == 0) ? C0   : C1;
    @(negedge clk);
    check("draw_busy",  32'(get_busy(w)), 32'h1);
    check("hold_board", get_board(w), prev_board[w]);
    check("hold_lit",   get_lit(w),   prev_lit[w]);
    check("hold_fb",    32'(get_fb(w)), 32'(prev_fb[w]));
    s         = m_lfsr;
    found     = 1'b0;
    exp_lat   = tr;
    exp_board = (32'd1 << mn) - 32'd1;
    exp_fb    = 1'b1;
    for (int i = 0; i < tr; i++) begin
      cand = s & ((32'd1 << cells) - 32'd1);
      if (!found && popc(cand) >= mn && popc(cand) <= mx) begin
        found     = 1'b1;
        exp_board = cand;
        exp_lat   = i + 1;
        exp_fb    = 1'b0;
      end
      s = lfsr_step(s);
    end
    lat = 0;
    while (!get_valid(w) && lat < MAXW) begin
      @(negedge clk);
      lat++;
    end
    check("latency",    32'(lat), 32'(exp_lat));
    check("board",      get_board(w), exp_board);
    check("lit_count",  get_lit(w), 32'(popc(exp_board)));
    check("fallback",   32'(get_fb(w)), 32'(exp_fb));
    check("show_busy",  32'(get_busy(w)), 32'h0);
    check("lit_pop",    get_lit(w), 32'(popc(get_board(w))));
    check("lit_range",  32'(int'(get_lit(w)) >= mn && int'(get_lit(w)) <= mx), 32'h1);
    prev_board[w] = exp_board;
    prev_lit[w]   = 32'(popc(exp_board));
    prev_fb[w]    = exp_fb;
  endtask

  task automatic show_hold(input int w, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive_start(w, (i % 2) == 0);
      @(negedge clk);
      check("show_valid", 32'(get_valid(w)), 32'h1);
      check("show_board", get_board(w), prev_board[w]);
    end
    drive_start(w, 1'b0);
  endtask

  // Acknowledge; with start_too the request is rechecked in IDLE and ARM is entered next cycle.
  task automatic ack_and_check(input int w, input logic start_too);
    drive_ack(w, 1'b1);
    drive_start(w, start_too);
    @(negedge clk);
    drive_ack(w, 1'b0);
    check("ack_valid", 32'(get_valid(w)), 32'h0);
    check("ack_busy",  32'(get_busy(w)),  32'h0);
    check("ack_board", get_board(w), prev_board[w]);
    check("ack_fb",    32'(get_fb(w)), 32'(prev_fb[w]));
    if (start_too) begin
      @(negedge clk);
      check("recheck_busy", 32'(get_busy(w)), 32'h1);
      drive_start(w, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start0 = 1'b0; ack0 = 1'b0; start1 = 1'b0; ack1 = 1'b0;
    m_lfsr = SEED;
    clear_prev();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Acknowledge outside SHOW has no effect.
    drive_ack(0, 1'b1);
    @(negedge clk);
    drive_ack(0, 1'b0);
    check("idle_ack_valid", 32'(valid0), 32'h0);
    check("idle_ack_busy",  32'(busy0),  32'h0);

    // Basic draw, then a long SHOW with start toggling.
    press(0, 1, 1'b0);
    draw_and_check(0);
    show_hold(0, 20);
    ack_and_check(0, 1'b0);

    // Long press with ack held during ARM, then ack+start together.
    press(0, 50, 1'b1);
    draw_and_check(0);
    ack_and_check(0, 1'b1);
    draw_and_check(0);
    ack_and_check(0, 1'b0);

    // Narrow instance: almost always the fallback pattern after MAX_TRIES draws.
    for (int r = 0; r < 4; r++) begin
      press(1, 1 + r, 1'b0);
      draw_and_check(1);
      ack_and_check(1, 1'b0);
    end

    // Reset asserted in the middle of a draw.
    press(1, 1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    m_lfsr = SEED;
    #1;
    check_all_zero("mid_draw_reset");
    clear_prev();
    @(negedge clk);
    reset = 1'b0;

    // First board after reset must come from the reset seed.
    press(0, 1, 1'b0);
    draw_and_check(0);
    ack_and_check(0, 1'b0);

    // Randomized press/release/ack cycles on the default instance.
    for (int r = 0; r < 100; r++) begin
      press(0, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
      draw_and_check(0);
      if ($urandom_range(0, 1) == 1) show_hold(0, int'($urandom_range(1, 3)));
      ack_and_check(0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
